// File: rtl/pixel_scheduler_pkg.sv
// Shared types and constants for the pixel scheduler: FSM state encoding,
// default frame geometry, coordinate widths and the in-set colour.
package pixel_scheduler_pkg;

   localparam int H_RES_DEFAULT = 640;
   localparam int V_RES_DEFAULT = 480;

   localparam int X_W    = 10;
   localparam int Y_W    = 9;
   localparam int ITER_W = 8;
   localparam int RGB_W  = 24;

   localparam logic [RGB_W-1:0] IN_SET_COLOR = 24'h010101;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_CALC = 3'd2,
      OUTPUT    = 3'd3,
      ADVANCE   = 3'd4,
      DONE      = 3'd5
   } state_t;

endpackage

// File: rtl/pixel_scheduler_color_converter.sv
// Combinational mapping from an iteration result to a grey-scale pixel;
// points inside the set get a fixed near-black colour.
module color_converter
   import pixel_scheduler_pkg::*;
(
   input  logic [ITER_W-1:0] iteration,
   input  logic              ismandelbrot,
   output logic [RGB_W-1:0]  rgb
);

   assign rgb = ismandelbrot ? IN_SET_COLOR : {iteration, iteration, iteration};

endmodule

// File: rtl/pixel_scheduler.sv
// Walks a frame in raster order, launching the iteration engine per pixel
// and handing each converted colour to a ready/valid pixel sink.
module pixel_scheduler
   import pixel_scheduler_pkg::*;
#(
   parameter int H_RES = H_RES_DEFAULT,
   parameter int V_RES = V_RES_DEFAULT
)
(
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              abort,
   output logic              calc_start,
   output logic [X_W-1:0]    calc_x,
   output logic [Y_W-1:0]    calc_y,
   input  logic              calc_done,
   input  logic [ITER_W-1:0] iteration,
   input  logic              ismandelbrot,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [RGB_W-1:0]  pix_rgb,
   output logic              busy,
   output logic              frame_done
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

   state_t           state_q, state_d;
   logic [X_W-1:0]   x_q, x_d;
   logic [Y_W-1:0]   y_q, y_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic [RGB_W-1:0] conv_rgb;

   color_converter u_color_converter (
      .iteration    (iteration),
      .ismandelbrot (ismandelbrot),
      .rgb          (conv_rgb)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         rgb_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         rgb_q   <= rgb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      rgb_d   = rgb_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LAUNCH;
               x_d     = '0;
               y_d     = '0;
            end
         end
         // calc_done is not looked at here, so a strobe coincident with
         // calc_start can never be mistaken for this pixel's result.
         LAUNCH: state_d = WAIT_CALC;
         WAIT_CALC: begin
            if (calc_done) begin
               rgb_d   = conv_rgb;
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (pix_ready) state_d = ADVANCE;
         end
         ADVANCE: begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
               state_d = DONE;
            end else if (x_q < X_LAST) begin
               x_d     = x_q + 1'b1;
               state_d = LAUNCH;
            end else begin
               x_d     = '0;
               y_d     = y_q + 1'b1;
               state_d = LAUNCH;
            end
         end
         DONE: begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
         end
         default: begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
         end
      endcase

      // Abort overrides every transition chosen above.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         x_d     = '0;
         y_d     = '0;
      end
   end

   assign calc_start = (state_q == LAUNCH);
   assign pix_valid  = (state_q == OUTPUT);
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);
   assign calc_x     = x_q;
   assign calc_y     = y_q;
   assign pix_rgb    = rgb_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x2 frame: raster order, colour
// mapping, sink back-pressure, abort, asynchronous reset and ignored inputs.
module tb_pixel_scheduler;

   logic        clk = 1'b0;
   logic        nrst;
   logic        start;
   logic        abort;
   logic        calc_start;
   logic [9:0]  calc_x;
   logic [8:0]  calc_y;
   logic        calc_done;
   logic [7:0]  iteration;
   logic        ismandelbrot;
   logic        pix_valid;
   logic        pix_ready;
   logic [23:0] pix_rgb;
   logic        busy;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int fd_count = 0;

   pixel_scheduler #(.H_RES(4), .V_RES(2)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .start        (start),
      .abort        (abort),
      .calc_start   (calc_start),
      .calc_x       (calc_x),
      .calc_y       (calc_y),
      .calc_done    (calc_done),
      .iteration    (iteration),
      .ismandelbrot (ismandelbrot),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_rgb      (pix_rgb),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_count++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_launch();
      int n = 0;
      while (calc_start !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("launch_seen", 32'(calc_start), 32'd1);
   endtask

   // Serves one pixel from LAUNCH to the cycle after ADVANCE.
   task automatic serve_pixel(input int x, input int y, input logic [7:0] it,
                              input logic mand, input logic [23:0] exp_rgb,
                              input int stall, input bit early_done);
      wait_launch();
      chk("launch_x", 32'(calc_x), 32'(x));
      chk("launch_y", 32'(calc_y), 32'(y));
      if (early_done) calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      chk("wait_no_start", 32'(calc_start), 32'd0);
      chk("wait_no_valid", 32'(pix_valid), 32'd0);
      tick();
      tick();
      calc_done    = 1'b1;
      iteration    = it;
      ismandelbrot = mand;
      pix_ready    = (stall == 0);
      tick();
      calc_done    = 1'b0;
      iteration    = 8'h00;
      ismandelbrot = 1'b0;
      chk("out_valid", 32'(pix_valid), 32'd1);
      chk("out_rgb", 32'(pix_rgb), 32'(exp_rgb));
      chk("out_x", 32'(calc_x), 32'(x));
      chk("out_y", 32'(calc_y), 32'(y));
      for (int k = 0; k < stall; k++) begin
         if (k == 2) start = 1'b1;
         tick();
         start = 1'b0;
         chk("stall_valid", 32'(pix_valid), 32'd1);
         chk("stall_rgb", 32'(pix_rgb), 32'(exp_rgb));
         chk("stall_x", 32'(calc_x), 32'(x));
      end
      pix_ready = 1'b1;
      tick();
      chk("adv_no_valid", 32'(pix_valid), 32'd0);
      tick();
   endtask

   logic [7:0]  it_tab  [8] = '{8'h2A, 8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
   logic        md_tab  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [23:0] rgb_tab [8] = '{24'h2A2A2A, 24'h010101, 24'h101010, 24'h202020,
                                24'h303030, 24'h404040, 24'h010101, 24'h606060};

   initial begin
      nrst = 1'b0; start = 1'b0; abort = 1'b0; calc_done = 1'b0;
      iteration = 8'h00; ismandelbrot = 1'b0; pix_ready = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(pix_valid), 32'd0);
      chk("rst_calc_start", 32'(calc_start), 32'd0);
      chk("rst_rgb", 32'(pix_rgb), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      tick();

      // Frame 1: full 4x2 raster with the engine answering 3 cycles late.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("f1_start_latency", 32'(calc_start), 32'd1);
      for (int i = 0; i < 8; i++)
         serve_pixel(i % 4, i / 4, it_tab[i], md_tab[i], rgb_tab[i], 0, (i == 0));
      chk("f1_frame_done", 32'(frame_done), 32'd1);
      tick();
      chk("f1_busy_after", 32'(busy), 32'd0);
      chk("f1_x_cleared", 32'(calc_x), 32'd0);
      chk("f1_y_cleared", 32'(calc_y), 32'd0);
      chk("f1_fd_count", 32'(fd_count), 32'd1);

      // Spurious result strobe while idle.
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      tick();
      chk("idle_done_busy", 32'(busy), 32'd0);
      chk("idle_done_valid", 32'(pix_valid), 32'd0);

      // Frame 2: back-pressure at (2,0), then abort while computing (1,1).
      start = 1'b1;
      tick();
      start = 1'b0;
      serve_pixel(0, 0, 8'h55, 1'b0, 24'h555555, 0, 1'b0);
      serve_pixel(1, 0, 8'h66, 1'b1, 24'h010101, 0, 1'b0);
      serve_pixel(2, 0, 8'h77, 1'b0, 24'h777777, 5, 1'b0);
      serve_pixel(3, 0, 8'h88, 1'b0, 24'h888888, 0, 1'b0);
      serve_pixel(0, 1, 8'h99, 1'b0, 24'h999999, 0, 1'b0);
      wait_launch();
      chk("ab_launch_x", 32'(calc_x), 32'd1);
      chk("ab_launch_y", 32'(calc_y), 32'd1);
      tick();
      chk("ab_wait_busy", 32'(busy), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_valid", 32'(pix_valid), 32'd0);
      chk("ab_x", 32'(calc_x), 32'd0);
      chk("ab_y", 32'(calc_y), 32'd0);
      calc_done = 1'b1;
      tick();
      calc_done = 1'b0;
      tick();
      tick();
      chk("ab_stay_idle", 32'(busy), 32'd0);
      chk("ab_no_frame_done", 32'(fd_count), 32'd1);

      // Frame 3: restart at origin, then reset asynchronously during OUTPUT.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("f3_calc_start", 32'(calc_start), 32'd1);
      chk("f3_x", 32'(calc_x), 32'd0);
      chk("f3_y", 32'(calc_y), 32'd0);
      tick();
      tick();
      tick();
      calc_done = 1'b1;
      iteration = 8'h33;
      pix_ready = 1'b0;
      tick();
      calc_done = 1'b0;
      chk("f3_out_valid", 32'(pix_valid), 32'd1);
      chk("f3_out_rgb", 32'(pix_rgb), 32'h00333333);
      #2;
      nrst = 1'b0;
      #1;
      chk("arst_valid", 32'(pix_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rgb", 32'(pix_rgb), 32'd0);
      chk("arst_calc_start", 32'(calc_start), 32'd0);
      chk("arst_frame_done", 32'(frame_done), 32'd0);
      chk("arst_x", 32'(calc_x), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      pix_ready = 1'b1;
      tick();
      chk("post_rst_idle", 32'(busy), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_rst_launch", 32'(calc_start), 32'd1);
      chk("post_rst_x", 32'(calc_x), 32'd0);
      chk("post_rst_y", 32'(calc_y), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameter H_RES, default 640, giving pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, giving lines per frame.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle frame request.
REQ-006 SHALL have port abort  input  1  synchronous frame cancel.
REQ-007 SHALL have port calc_start  output  1  one-cycle pulse launching the iteration engine.
REQ-008 SHALL have port calc_x  output  10  current pixel column.
REQ-009 SHALL have port calc_y  output  9  current pixel row.
REQ-010 SHALL have port calc_done  input  1  iteration engine result strobe.
REQ-011 SHALL have port iteration  input  8  escape count, sampled only with calc_done.
REQ-012 SHALL have port ismandelbrot  input  1  in-set flag, sampled only with calc_done.
REQ-013 SHALL have port pix_valid  output  1  pixel word available.
REQ-014 SHALL have port pix_ready  input  1  sink accepts pixel.
REQ-015 SHALL have port pix_rgb  output  24  converted colour {R,G,B}.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after last pixel accepted.

Function
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT_CALC, OUTPUT, ADVANCE, DONE.
REQ-019 IDLE: start=1 -> LAUNCH with x=0, y=0; other inputs ignored.
REQ-020 LAUNCH: assert calc_start for exactly one cycle -> WAIT_CALC; start-to-calc_start latency is 1 cycle.
REQ-021 WAIT_CALC: on calc_done=1, register colour of (iteration, ismandelbrot) into pix_rgb -> OUTPUT; pix_valid rises the next cycle.
REQ-022 Colour rule: ismandelbrot=1 -> 24'h010101; else {iteration, iteration, iteration}.
REQ-023 OUTPUT: pix_valid=1, pix_rgb and calc_x/calc_y held stable until pix_valid&&pix_ready; then -> ADVANCE.
REQ-024 ADVANCE: x<H_RES-1 -> x+1; else x=0 and y+1; -> LAUNCH, unless pixel was (H_RES-1, V_RES-1) -> DONE.
REQ-025 DONE: frame_done=1 for one cycle -> IDLE; x, y return to 0.
REQ-026 calc_x/calc_y SHALL remain constant from LAUNCH through OUTPUT of the same pixel.
REQ-027 calc_done outside WAIT_CALC SHALL be ignored; calc_done in the same cycle as calc_start SHALL be ignored.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state -> IDLE next cycle, pix_valid=0, no frame_done, x=y=0; abort has priority over all other transitions.
REQ-030 pix_valid SHALL never drop without a handshake, except on abort or reset.
REQ-031 Counters SHALL never exceed H_RES-1 / V_RES-1; no wrap beyond the frame.

Reset
REQ-032 nrst=0 SHALL immediately force IDLE, x=0, y=0, pix_rgb=0, pix_valid=0, calc_start=0, busy=0, frame_done=0.
REQ-033 Reset mid-frame SHALL discard the in-flight pixel; the next start begins at (0,0).

Structure
REQ-034 Shared package SHALL hold the state enum type, H_RES/V_RES defaults, coordinate widths and the in-set colour constant 24'h010101.
REQ-035 Colour mapping SHALL be a single instance of the existing color_converter sub-module; its output is registered here.

Verification
REQ-036 H_RES=4, V_RES=2; start, calc_done 3 cycles after each calc_start, pix_ready=1 -> 8 pixels in raster order (0,0)..(3,1), one frame_done, busy low after.
REQ-037 iteration=8'h2A, ismandelbrot=0 -> pix_rgb=24'h2A2A2A; ismandelbrot=1, iteration=8'hFF -> 24'h010101.
REQ-038 pix_ready held 0 for 5 cycles at pixel (2,0) -> pix_valid, pix_rgb, calc_x=2 stable; advance exactly once when ready=1.
REQ-039 abort during WAIT_CALC of pixel (1,1) -> IDLE next cycle, no frame_done; new start launches at (0,0).
REQ-040 nrst pulsed low during OUTPUT -> all outputs 0 asynchronously; spurious calc_done in IDLE and start while busy produce no effect.
